mod_barrett_pipe: RTL and testbench

Pipelined, parametrised Barrett reducer. It computes r = x mod M and q = floor(x / M) for a compile-time modulus M, with valid/ready flow control and a passthrough tag. It replaces the fixed M=100 combinational reducer wherever a reduction sits on a registered datapath, such as dial-position and wrap counters. It is also the building block for any modulus other than 100.

---
 rtl/mod_barrett_pkg.sv | 25 ++
 rtl/mod_barrett_stage.sv | 29 ++
 rtl/mod_barrett_pipe.sv | 139 +++++++++++++
 tb/tb_mod_barrett_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_barrett_pkg.sv
// Shared helpers for the pipelined Barrett reducer: derived width and reciprocal constants.
package mod_barrett_pkg;

    function automatic int barrett_k(input int m);
        return $clog2(m);
    endfunction

    // Fixed-point reciprocal floor(2^(2k) / m); fits k+1 bits for any legal m.
    function automatic longint barrett_mu(input int m, input int k);
        return (longint'(1) << (2 * k)) / longint'(m);
    endfunction

    function automatic int barrett_qw(input int xw, input int l);
        return xw - l + 1;
    endfunction

    function automatic int barrett_pw(input int xw, input int l);
        return barrett_qw(xw, l) + (l + 1);
    endfunction

    function automatic int barrett_r0w(input int xw);
        return xw + 1;
    endfunction

endpackage

// File: rtl/mod_barrett_stage.sv
// Generic valid/ready register slice; one bubble-free pipeline stage with a reset payload.
module mod_barrett_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready = !rst && (!dn_valid || dn_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/mod_barrett_pipe.sv
// Three-stage Barrett reducer r = x mod M (and q = x / M with MOD_BARRETT_QUOT_EN defined).
module mod_barrett_pipe
    import mod_barrett_pkg::*;
#(
    parameter int M  = 100,
    parameter int K  = barrett_k(M),
    parameter int XW = 2 * K,
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_r,
`ifdef MOD_BARRETT_QUOT_EN
    output logic [XW-K:0] out_q,
`endif
    output logic [TW-1:0] out_tag
);

    localparam int L   = ((XW + 1) / 2 > K) ? (XW + 1) / 2 : K;
    localparam int QW  = barrett_qw(XW, L);
    localparam int PW  = barrett_pw(XW, L);
    localparam int R0W = barrett_r0w(XW);
    localparam logic [K:0]     MU   = (K + 1)'(barrett_mu(M, K));
    localparam logic [R0W-1:0] M_R0 = R0W'(M);

    if (M < 2 || M >= 65536) begin : g_bad_m
        $error("mod_barrett_pipe: M=%0d outside 2..65535", M);
    end
    if (XW > 2 * K || XW < K) begin : g_bad_xw
        $error("mod_barrett_pipe: XW=%0d outside K..2K (K=%0d)", XW, K);
    end

    // S1: scaled estimate product
    localparam int W1 = PW + XW + TW;
    logic [QW-1:0] q1;
    logic [PW-1:0] p_in;
    logic [W1-1:0] s1_data;
    logic          v1, rdy2;

    assign q1   = in_x[XW-1:L-1];
    assign p_in = PW'(q1) * PW'(MU);

    mod_barrett_stage #(.W(W1)) u_s1 (
        .clk(clk), .rst(rst),
        .up_valid(in_valid), .up_ready(in_ready), .up_data({p_in, in_x, in_tag}),
        .dn_valid(v1), .dn_ready(rdy2), .dn_data(s1_data)
    );

    logic [PW-1:0]  s1_p;
    logic [XW-1:0]  s1_x;
    logic [TW-1:0]  s1_tag;
    logic [QW-1:0]  q3;
    logic [R0W-1:0] r0;
    logic [L:0]     unused_p_lo;

    assign s1_p        = s1_data[W1-1 -: PW];
    assign s1_x        = s1_data[TW +: XW];
    assign s1_tag      = s1_data[TW-1:0];
    assign q3          = s1_p[PW-1:L+1];
    assign unused_p_lo = s1_p[L:0];
    // Estimate never overshoots, so the wrapped subtraction is the true non-negative r0.
    assign r0          = R0W'(s1_x) - R0W'(q3) * M_R0;

    // S2: partial remainder
`ifdef MOD_BARRETT_QUOT_EN
    localparam int W2 = QW + R0W + TW;
    logic [W2-1:0] s2_in;
    assign s2_in = {q3, r0, s1_tag};
`else
    localparam int W2 = R0W + TW;
    logic [W2-1:0] s2_in;
    assign s2_in = {r0, s1_tag};
`endif
    logic [W2-1:0] s2_data;
    logic          v2, rdy3;

    mod_barrett_stage #(.W(W2)) u_s2 (
        .clk(clk), .rst(rst),
        .up_valid(v1), .up_ready(rdy2), .up_data(s2_in),
        .dn_valid(v2), .dn_ready(rdy3), .dn_data(s2_data)
    );

    logic [R0W-1:0] s2_r0, r_a, r_b;
    logic [TW-1:0]  s2_tag;
    logic           c1, c2;
    logic [K-1:0]   r_fin;
    logic [R0W-1:K] unused_r_hi;

    assign s2_r0       = s2_data[TW +: R0W];
    assign s2_tag      = s2_data[TW-1:0];
    assign c1          = (s2_r0 >= M_R0);
    assign r_a         = c1 ? s2_r0 - M_R0 : s2_r0;
    assign c2          = (r_a >= M_R0);
    assign r_b         = c2 ? r_a - M_R0 : r_a;
    assign r_fin       = r_b[K-1:0];
    assign unused_r_hi = r_b[R0W-1:K];

    // S3: corrected result
`ifdef MOD_BARRETT_QUOT_EN
    localparam int W3 = QW + K + TW;
    logic [QW-1:0] s2_q3, qf;
    logic [W3-1:0] s3_in;
    assign s2_q3 = s2_data[W2-1 -: QW];
    assign qf    = s2_q3 + QW'(c1) + QW'(c2);
    assign s3_in = {qf, r_fin, s2_tag};
`else
    localparam int W3 = K + TW;
    logic [W3-1:0] s3_in;
    assign s3_in = {r_fin, s2_tag};
`endif
    logic [W3-1:0] s3_data;

    mod_barrett_stage #(.W(W3)) u_s3 (
        .clk(clk), .rst(rst),
        .up_valid(v2), .up_ready(rdy3), .up_data(s3_in),
        .dn_valid(out_valid), .dn_ready(out_ready), .dn_data(s3_data)
    );

    assign out_r   = s3_data[TW +: K];
    assign out_tag = s3_data[TW-1:0];
`ifdef MOD_BARRETT_QUOT_EN
    assign out_q   = s3_data[W3-1 -: QW];
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && out_valid) begin
            assert ({1'b0, out_r} < (K + 1)'(M));
        end
    end
`endif

endmodule

// File: tb/tb_mod_barrett_pipe.sv
// Self-checking bench for mod_barrett_pipe: directed scenarios plus randomized flow against a % and / model.
module tb_mod_barrett_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [13:0] in_x;
    logic [7:0]  in_tag, out_tag;
    logic [6:0]  out_r;
`ifdef MOD_BARRETT_QUOT_EN
    logic [7:0]  out_q;
`endif

    logic       v7, ir7, ov7, rdy7;
    logic [5:0] x7;
    logic [3:0] tag7, ot7;
    logic [2:0] or7;
`ifdef MOD_BARRETT_QUOT_EN
    logic [3:0] oq7;
`endif

    always #5 clk = ~clk;

    mod_barrett_pipe #(.M(100), .XW(14), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
`ifdef MOD_BARRETT_QUOT_EN
        .out_q(out_q),
`endif
        .out_tag(out_tag)
    );

    mod_barrett_pipe #(.M(7), .XW(6), .TW(4)) dut7 (
        .clk(clk), .rst(rst),
        .in_valid(v7), .in_ready(ir7), .in_x(x7), .in_tag(tag7),
        .out_valid(ov7), .out_ready(rdy7), .out_r(or7),
`ifdef MOD_BARRETT_QUOT_EN
        .out_q(oq7),
`endif
        .out_tag(ot7)
    );

    typedef struct {
        int x;
        int tag;
    } word_t;

    word_t sb[$];
    int    tagq[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    n_out = 0;
    int    first_in_cyc, first_out_cyc, last_out_cyc;
    logic  in_fire, out_fire;
    logic  s_in_ready, s_out_valid;
    logic [6:0] s_out_r;
    logic [7:0] s_out_tag;

    task automatic check(input string name, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score transfers, then pass the edge.
    task automatic step();
        word_t e;
        cyc++;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_r     = out_r;
        s_out_tag   = out_tag;
        in_fire     = in_valid && in_ready;
        out_fire    = out_valid && out_ready;
        if (out_fire === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", longint'(out_valid), 0);
            end else begin
                e = sb.pop_front();
                check("r", longint'(out_r), longint'(e.x % 100));
                check("tag", longint'(out_tag), longint'(e.tag));
`ifdef MOD_BARRETT_QUOT_EN
                check("q", longint'(out_q), longint'(e.x / 100));
`endif
                case (e.x)
                    16383: check("spot_16383_r", longint'(out_r), 83);
                    100:   check("spot_100_r", longint'(out_r), 0);
                    99:    check("spot_99_r", longint'(out_r), 99);
                    default: ;
                endcase
                tagq.push_back(e.tag);
                n_out++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
        end
        if (in_fire === 1'b1) begin
            sb.push_back('{x: int'(in_x), tag: int'(in_tag)});
            if (first_in_cyc < 0) first_in_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (rst) sb.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) step();
        check("drain_empty", longint'(sb.size()), 0);
    endtask

    initial begin
        int acc, n0, got;
        logic have;
        logic [6:0] hold_r;
        logic [7:0] hold_tag;

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b1;
        v7 = 1'b0; x7 = '0; tag7 = '0; rdy7 = 1'b1;
        first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;

        // Reset state
        step();
        step();
        check("rst_out_valid", longint'(s_out_valid), 0);
        check("rst_out_r", longint'(s_out_r), 0);
        check("rst_out_tag", longint'(s_out_tag), 0);
        check("rst_in_ready", longint'(s_in_ready), 0);
`ifdef MOD_BARRETT_QUOT_EN
        check("rst_out_q", longint'(out_q), 0);
`endif
        rst = 1'b0;
        step();
        check("in_ready_after_rst", longint'(s_in_ready), 1);

        // Exhaustive sweep, full throughput
        first_in_cyc = -1; first_out_cyc = -1; n0 = n_out;
        for (int x = 0; x < 16384; x++) begin
            in_valid = 1'b1; in_x = 14'(x); in_tag = 8'(x);
            step();
            check("sweep_in_ready", longint'(in_fire), 1);
        end
        in_valid = 1'b0;
        drain(20);
        check("sweep_count", longint'(n_out - n0), 16384);
        check("sweep_latency", longint'(first_out_cyc - first_in_cyc), 3);
        check("sweep_throughput", longint'(last_out_cyc - first_out_cyc), 16383);

        // Backpressure: only three words fit
        tagq.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_x = 14'($urandom_range(0, 16383)); in_tag = 8'd1;
        acc = 0; have = 1'b0; hold_r = '0; hold_tag = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (in_fire) begin
                acc++;
                if (in_tag < 8'd4) begin
                    in_tag = in_tag + 8'd1;
                    in_x = 14'($urandom_range(0, 16383));
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (s_out_valid) begin
                if (!have) begin
                    have = 1'b1; hold_r = s_out_r; hold_tag = s_out_tag;
                end else begin
                    check("stall_r", longint'(s_out_r), longint'(hold_r));
                    check("stall_tag", longint'(s_out_tag), longint'(hold_tag));
                end
            end
        end
        check("bp_accepted", longint'(acc), 3);
        check("bp_in_ready_full", longint'(s_in_ready), 0);
        check("bp_head_tag", longint'(s_out_tag), 1);
        out_ready = 1'b1;
        step();
        check("bp_accept_while_drain", longint'(in_fire), 1);
        if (in_fire) in_valid = 1'b0;
        drain(20);
        check("bp_out_count", longint'(tagq.size()), 4);
        for (int i = 0; i < 4 && i < tagq.size(); i++) check("bp_tag_order", longint'(tagq[i]), longint'(i + 1));

        // Random valid/ready at 50%
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (in_fire) acc++;
            if (in_fire || !in_valid) begin
                if (acc < 10000 && $urandom_range(0, 1) == 1) begin
                    in_valid = 1'b1;
                    in_x = 14'($urandom_range(0, 16383));
                    in_tag = 8'($urandom_range(0, 255));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("rand_accepted", longint'(acc), 10000);
        in_valid = 1'b0; out_ready = 1'b1;
        drain(20);

        // Reset with two words in flight
        out_ready = 1'b0; in_valid = 1'b1; in_x = 14'd1234; in_tag = 8'hA1;
        step();
        in_x = 14'd4321; in_tag = 8'hA2;
        step();
        in_valid = 1'b0;
        check("mid_in_flight", longint'(sb.size()), 2);
        rst = 1'b1;
        step();
        check("mid_rst_in_ready", longint'(s_in_ready), 0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        check("mid_rst_out_valid", longint'(s_out_valid), 0);
        check("mid_rst_out_r", longint'(s_out_r), 0);
        check("mid_after_in_ready", longint'(s_in_ready), 1);
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            step();
            check("mid_no_emit", longint'(s_out_valid), 0);
        end
        check("mid_no_words", longint'(n_out - n0), 0);

        // Small modulus M=7
        v7 = 1'b1; x7 = 6'd63; tag7 = 4'd1;
        @(negedge clk);
        check("m7_in_ready", longint'(ir7), 1);
        @(posedge clk); #1;
        x7 = 6'd62; tag7 = 4'd2;
        @(negedge clk);
        @(posedge clk); #1;
        v7 = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && got < 2; i++) begin
            @(negedge clk);
            if (ov7) begin
                if (got == 0) begin
                    check("m7_63_r", longint'(or7), 0);
                    check("m7_63_tag", longint'(ot7), 1);
`ifdef MOD_BARRETT_QUOT_EN
                    check("m7_63_q", longint'(oq7), 9);
`endif
                end else begin
                    check("m7_62_r", longint'(or7), 6);
                    check("m7_62_tag", longint'(ot7), 2);
`ifdef MOD_BARRETT_QUOT_EN
                    check("m7_62_q", longint'(oq7), 8);
`endif
                end
                got++;
            end
            @(posedge clk); #1;
        end
        check("m7_count", longint'(got), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
